seg7_scan_driver: RTL and testbench

Parametrised time-multiplexed driver for a bank of common-anode 7-segment digits, generalising fixed 3-to-8 digit selection into a full scanning engine. It cycles through `N_DIGITS` digit positions at a programmable rate and decodes a 4-bit hex nibble per digit into segment patterns. It supports per-digit enable, decimal points, anti-ghosting dead time, output polarity selection and frame-coherent (tear-free) data capture. It sits between the display-data registers and the board's `an`/`seg`/`dp` pins.

---
 rtl/seg7_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode 7-segment scanning driver
// Frame-coherent shadow capture, per-digit enable, dead time and selectable pin polarity.
module seg7_scan_driver #(
   parameter int N_DIGITS    = 8,
   parameter int DIV_CYCLES  = 100000,
   parameter int DEAD_CYCLES = 1,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*N_DIGITS-1:0]   data,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic [N_DIGITS-1:0]     digit_en,
   output logic [N_DIGITS-1:0]     an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_start
);

   localparam int IW = ($clog2(N_DIGITS) < 1) ? 1 : $clog2(N_DIGITS);
   localparam int DW = ($clog2(DIV_CYCLES) < 1) ? 1 : $clog2(DIV_CYCLES);

   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV_CYCLES - 1);
   localparam logic [DW-1:0] DEAD_V   = DW'(DEAD_CYCLES);

   // Pin-level "off" value; active-high internal values are XORed with it.
   localparam logic                POL     = (ACTIVE_LOW != 0);
   localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{POL}};
   localparam logic [6:0]          SEG_OFF = {7{POL}};

   logic [DW-1:0]           div;
   logic [IW-1:0]           idx;
   logic [4*N_DIGITS-1:0]   shadow_data;
   logic [N_DIGITS-1:0]     shadow_dp;
   logic [N_DIGITS-1:0]     shadow_en;
   logic                    primed;

   logic                    tick;
   logic                    wrap;
   logic                    in_window;
   logic                    lit;
   logic [3:0]              nibble;
   logic [6:0]              pattern;

   logic [N_DIGITS-1:0]     an_next;
   logic [6:0]              seg_next;
   logic                    dp_next;
   logic                    frame_start_next;

   assign tick = (div == DIV_LAST);
   assign wrap = tick && (idx == IDX_LAST);

   // With no dead time the window is always open; avoid a constant compare.
   generate
      if (DEAD_CYCLES == 0) begin : g_no_dead
         assign in_window = 1'b1;
      end else begin : g_dead
         assign in_window = (div >= DEAD_V);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
         idx <= '0;
      end else if (tick) begin
         div <= '0;
         idx <= wrap ? '0 : idx + 1'b1;
      end else begin
         div <= div + 1'b1;
      end
   end

   // Shadow copies only change on the frame wrap, so a frame never tears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_data <= '0;
         shadow_dp   <= '0;
         shadow_en   <= '0;
         primed      <= 1'b0;
      end else if (wrap) begin
         shadow_data <= data;
         shadow_dp   <= dp_in;
         shadow_en   <= digit_en;
         primed      <= 1'b1;
      end
   end

   function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
      logic [6:0] result;
      case (value)
         4'h0:    result = 7'b1000000;
         4'h1:    result = 7'b1111001;
         4'h2:    result = 7'b0100100;
         4'h3:    result = 7'b0110000;
         4'h4:    result = 7'b0011001;
         4'h5:    result = 7'b0010010;
         4'h6:    result = 7'b0000010;
         4'h7:    result = 7'b1111000;
         4'h8:    result = 7'b0000000;
         4'h9:    result = 7'b0010000;
         4'hA:    result = 7'b0001000;
         4'hB:    result = 7'b0000011;
         4'hC:    result = 7'b1000110;
         4'hD:    result = 7'b0100001;
         4'hE:    result = 7'b0000110;
         default: result = 7'b0001110;
      endcase
      return result;
   endfunction

   assign nibble  = shadow_data[{idx, 2'b00} +: 4];
   assign pattern = hex_to_seg(nibble);
   assign lit     = primed && shadow_en[idx] && in_window;

   always_comb begin
      an_next          = '0;
      seg_next         = '0;
      dp_next          = 1'b0;
      frame_start_next = primed && (idx == '0) && (div == '0);
      if (lit) begin
         an_next[idx] = 1'b1;
         seg_next     = ~pattern;
         dp_next      = shadow_dp[idx];
      end
      an_next  = an_next ^ AN_OFF;
      seg_next = seg_next ^ SEG_OFF;
      dp_next  = dp_next ^ POL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an          <= AN_OFF;
         seg         <= SEG_OFF;
         dp          <= POL;
         frame_start <= 1'b0;
      end else begin
         an          <= an_next;
         seg         <= seg_next;
         dp          <= dp_next;
         frame_start <= frame_start_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
// Two instances (active-low and active-high pins) checked against a frame-arithmetic model.
module tb_seg7_scan_driver;

   localparam int N    = 8;
   localparam int DIV  = 4;
   localparam int DEAD = 1;
   localparam int FRAME = N * DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data;
   logic [7:0]  dp_in;
   logic [7:0]  digit_en;

   logic [7:0]  an0, an1;
   logic [6:0]  seg0, seg1;
   logic        dp0, dp1;
   logic        fs0, fs1;

   always #5 clk = ~clk;

   seg7_scan_driver #(.N_DIGITS(N), .DIV_CYCLES(DIV), .DEAD_CYCLES(DEAD), .ACTIVE_LOW(1)) dut_lo (
      .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .digit_en(digit_en),
      .an(an0), .seg(seg0), .dp(dp0), .frame_start(fs0)
   );

   seg7_scan_driver #(.N_DIGITS(N), .DIV_CYCLES(DIV), .DEAD_CYCLES(DEAD), .ACTIVE_LOW(0)) dut_hi (
      .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .digit_en(digit_en),
      .an(an1), .seg(seg1), .dp(dp1), .frame_start(fs1)
   );

   int total = 0;
   int bad   = 0;
   int e     = 0;

   logic [31:0] sh_data;
   logic [7:0]  sh_dp;
   logic [7:0]  sh_en;

   logic [6:0] hex_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, expv, e);
      end
   endtask

   // One clock: expected pins after edge e come from the scan position m = e-1.
   task automatic step();
      int m, p, slot, dv;
      logic lit;
      logic [7:0] an_e, an_h;
      logic [6:0] seg_e, seg_h;
      logic dp_e, dp_h, fs_e;
      @(posedge clk);
      e++;
      m    = e - 1;
      p    = m % FRAME;
      slot = p / DIV;
      dv   = p % DIV;
      lit   = (m >= FRAME) && sh_en[slot] && (dv >= DEAD);
      an_e  = lit ? ~(8'd1 << slot) : 8'hFF;
      seg_e = lit ? hex_tab[sh_data[slot*4 +: 4]] : 7'h7F;
      dp_e  = lit ? ~sh_dp[slot] : 1'b1;
      fs_e  = (m >= FRAME) && (p == 0);
      an_h  = ~an_e;
      seg_h = ~seg_e;
      dp_h  = ~dp_e;
      if (e % FRAME == 0) begin
         sh_data = data;
         sh_dp   = dp_in;
         sh_en   = digit_en;
      end
      #1;
      chk("an_lo", an0, an_e);
      chk("seg_lo", seg0, seg_e);
      chk("dp_lo", dp0, dp_e);
      chk("frame_start_lo", fs0, fs_e);
      chk("an_hi", an1, an_h);
      chk("seg_hi", seg1, seg_h);
      chk("dp_hi", dp1, dp_h);
      chk("frame_start_hi", fs1, fs_e);
   endtask

   // Reset is checked before any clock edge to prove it acts asynchronously.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_an_lo", an0, 8'hFF);
      chk("rst_seg_lo", seg0, 7'h7F);
      chk("rst_dp_lo", dp0, 1'b1);
      chk("rst_fs_lo", fs0, 1'b0);
      chk("rst_an_hi", an1, 8'h00);
      chk("rst_seg_hi", seg1, 7'h00);
      chk("rst_dp_hi", dp1, 1'b0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      e       = 0;
      sh_data = '0;
      sh_dp   = '0;
      sh_en   = '0;
   endtask

   initial begin
      rst      = 1'b0;
      data     = '0;
      dp_in    = '0;
      digit_en = '0;
      #2;
      do_reset();

      data     = 32'h76543210;
      digit_en = 8'hFF;
      repeat (48) step();

      data = 32'hFFFFFFFF;
      repeat (22) step();

      digit_en = 8'hAA;
      dp_in    = 8'h02;
      repeat (58) step();

      for (int i = 0; i < 96; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            data     = $urandom;
            digit_en = 8'($urandom);
            dp_in    = 8'($urandom);
         end
         step();
      end

      // Land in the middle of digit 5's slot, then reset.
      repeat (23) step();
      do_reset();

      data     = '0;
      digit_en = 8'hFF;
      dp_in    = '0;
      repeat (34) step();
      chk("pol_an_hi", an1, 8'h01);
      chk("pol_seg_hi", seg1, 7'b0111111);
      repeat (30) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
